// File: rtl/FPU_192_Package.sv
// Shared DD192 FPU definitions used by the multiply/divide normalization
// scheduler: field widths, the held request record, the source encoding and
// the round-robin pick helper.
package FPU_192_Package;

    localparam int EXPONENT_LENGTH           = 8;
    localparam int NORMALIZE_MANTISSA_LENGTH = 24;
    localparam int FORMAT_LENGTH             = 32;
    localparam int TAG_W                     = 3;

    // One pending normalization request as held in a scheduler slot.
    typedef struct packed {
        logic [EXPONENT_LENGTH-1:0]           exp;
        logic [NORMALIZE_MANTISSA_LENGTH-1:0] man;
        logic                                 sign;
        logic                                 redundant;
        logic [TAG_W-1:0]                     tag;
    } md_req_t;

    localparam md_req_t MD_REQ_ZERO = '0;

    // Which requester a grant or result belongs to.
    typedef enum logic {
        SRC_MUL = 1'b0,
        SRC_DIV = 1'b1
    } md_src_e;

    // Round-robin choice between the two slots. A lone full slot always
    // wins; on a tie the source that did not win last time is picked.
    function automatic md_src_e md_rr_pick(input logic    mul_full,
                                           input logic    div_full,
                                           input md_src_e last_grant);
        md_src_e pick;
        if (mul_full && div_full) begin
            pick = (last_grant == SRC_DIV) ? SRC_MUL : SRC_DIV;
        end else if (div_full) begin
            pick = SRC_DIV;
        end else begin
            pick = SRC_MUL;
        end
        return pick;
    endfunction

endpackage

// File: rtl/md_norm_sched_if.sv
// Bus bundle of md_norm_sched: both request handshakes, the drive/return
// path of the shared combinational normalizer and the result handshake.
// "slave" is the scheduler's view, "master" the surrounding pipeline's.
interface md_norm_sched_if;
    import FPU_192_Package::*;

    // multiplier request
    logic                                 mul_valid;
    logic                                 mul_ready;
    logic [EXPONENT_LENGTH-1:0]           mul_exp;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] mul_man;
    logic                                 mul_redundant;
    logic                                 mul_sign;
    logic [TAG_W-1:0]                     mul_tag;

    // divider request
    logic                                 div_valid;
    logic                                 div_ready;
    logic [EXPONENT_LENGTH-1:0]           div_exp;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] div_man;
    logic                                 div_sign;
    logic [TAG_W-1:0]                     div_tag;

    // shared normalizer
    logic [EXPONENT_LENGTH-1:0]           norm_exp;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] norm_mul_result;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] norm_div_result;
    logic                                 norm_redundant_mul;
    logic                                 norm_div_mul;
    logic                                 norm_sign;
    logic [FORMAT_LENGTH-1:0]             norm_result;
    logic                                 norm_overflow;
    logic                                 norm_underflow;

    // result
    logic                                 res_valid;
    logic                                 res_ready;
    logic [FORMAT_LENGTH-1:0]             res_data;
    logic                                 res_overflow;
    logic                                 res_underflow;
    logic                                 res_src;
    logic [TAG_W-1:0]                     res_tag;

    modport slave (
        input  mul_valid, mul_exp, mul_man, mul_redundant, mul_sign, mul_tag,
        output mul_ready,
        input  div_valid, div_exp, div_man, div_sign, div_tag,
        output div_ready,
        output norm_exp, norm_mul_result, norm_div_result,
        output norm_redundant_mul, norm_div_mul, norm_sign,
        input  norm_result, norm_overflow, norm_underflow,
        output res_valid, res_data, res_overflow, res_underflow, res_src, res_tag,
        input  res_ready
    );

    modport master (
        output mul_valid, mul_exp, mul_man, mul_redundant, mul_sign, mul_tag,
        input  mul_ready,
        output div_valid, div_exp, div_man, div_sign, div_tag,
        input  div_ready,
        input  norm_exp, norm_mul_result, norm_div_result,
        input  norm_redundant_mul, norm_div_mul, norm_sign,
        output norm_result, norm_overflow, norm_underflow,
        input  res_valid, res_data, res_overflow, res_underflow, res_src, res_tag,
        output res_ready
    );

endinterface

// File: rtl/md_req_slot.sv
// One-entry request holding register. A load wins over a drain in the same
// cycle so an issuing slot can be refilled back-to-back; flush empties it.
module md_req_slot
    import FPU_192_Package::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    load,
    input  logic    drain,
    input  md_req_t req_in,
    output logic    full,
    output md_req_t req_out
);

    logic    full_d;
    logic    full_q;
    md_req_t data_d;
    md_req_t data_q;

    // Next occupancy and payload: flush, then load, then drain, else hold.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush) begin
            full_d = 1'b0;
            data_d = MD_REQ_ZERO;
        end else if (load) begin
            full_d = 1'b1;
            data_d = req_in;
        end else if (drain) begin
            full_d = 1'b0;
            data_d = data_q;
        end else begin
            full_d = full_q;
            data_d = data_q;
        end
    end

    // Slot state register, emptied by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= MD_REQ_ZERO;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full    = full_q;
    assign req_out = data_q;

endmodule

// File: rtl/md_norm_sched.sv
// Two-requester scheduler for the shared multiply/divide post-normalizer.
// Each requester parks one request in its own slot; whenever the output
// register can take a value, one full slot is granted (round-robin on a
// tie), its fields drive the external normalizer and the normalizer answer
// is captured together with source and tag in the same cycle.
module md_norm_sched
    import FPU_192_Package::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    md_norm_sched_if.slave      bus
);

    // slot wiring
    md_req_t mul_in_s;
    md_req_t div_in_s;
    md_req_t mul_slot_s;
    md_req_t div_slot_s;
    logic    mul_full_s;
    logic    div_full_s;

    // scheduling
    logic    out_free_s;
    logic    issue_s;
    md_src_e grant_s;
    logic    mul_drain_s;
    logic    div_drain_s;
    logic    mul_ready_s;
    logic    div_ready_s;
    logic    mul_load_s;
    logic    div_load_s;
    md_src_e last_grant_d;
    md_src_e last_grant_q;

    // normalizer drive
    logic [EXPONENT_LENGTH-1:0]           norm_exp_s;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] norm_mul_result_s;
    logic [NORMALIZE_MANTISSA_LENGTH-1:0] norm_div_result_s;
    logic                                 norm_redundant_mul_s;
    logic                                 norm_div_mul_s;
    logic                                 norm_sign_s;

    // output stage
    logic                     res_valid_d;
    logic                     res_valid_q;
    logic [FORMAT_LENGTH-1:0] res_data_d;
    logic [FORMAT_LENGTH-1:0] res_data_q;
    logic                     res_overflow_d;
    logic                     res_overflow_q;
    logic                     res_underflow_d;
    logic                     res_underflow_q;
    logic                     res_src_d;
    logic                     res_src_q;
    logic [TAG_W-1:0]         res_tag_d;
    logic [TAG_W-1:0]         res_tag_q;

    // Pack incoming request fields; the divider never needs a right shift.
    always_comb begin
        mul_in_s.exp       = bus.mul_exp;
        mul_in_s.man       = bus.mul_man;
        mul_in_s.sign      = bus.mul_sign;
        mul_in_s.redundant = bus.mul_redundant;
        mul_in_s.tag       = bus.mul_tag;
        div_in_s.exp       = bus.div_exp;
        div_in_s.man       = bus.div_man;
        div_in_s.sign      = bus.div_sign;
        div_in_s.redundant = 1'b0;
        div_in_s.tag       = bus.div_tag;
    end

    md_req_slot u_mul_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (mul_load_s),
        .drain   (mul_drain_s),
        .req_in  (mul_in_s),
        .full    (mul_full_s),
        .req_out (mul_slot_s)
    );

    md_req_slot u_div_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (div_load_s),
        .drain   (div_drain_s),
        .req_in  (div_in_s),
        .full    (div_full_s),
        .req_out (div_slot_s)
    );

    // Issue/grant decision and the handshakes it frees up; a slot being
    // issued this cycle can accept its replacement in the same cycle.
    always_comb begin
        out_free_s  = !res_valid_q || bus.res_ready;
        issue_s     = !flush && out_free_s && (mul_full_s || div_full_s);
        grant_s     = md_rr_pick(mul_full_s, div_full_s, last_grant_q);
        mul_drain_s = issue_s && (grant_s == SRC_MUL);
        div_drain_s = issue_s && (grant_s == SRC_DIV);
        mul_ready_s = !flush && (!mul_full_s || mul_drain_s);
        div_ready_s = !flush && (!div_full_s || div_drain_s);
        mul_load_s  = bus.mul_valid && mul_ready_s;
        div_load_s  = bus.div_valid && div_ready_s;
    end

    // Route the granted slot onto the normalizer; idle drive is all zero.
    always_comb begin
        norm_exp_s           = '0;
        norm_mul_result_s    = '0;
        norm_div_result_s    = '0;
        norm_redundant_mul_s = 1'b0;
        norm_div_mul_s       = 1'b0;
        norm_sign_s          = 1'b0;
        if (issue_s) begin
            case (grant_s)
                SRC_MUL: begin
                    norm_exp_s           = mul_slot_s.exp;
                    norm_sign_s          = mul_slot_s.sign;
                    norm_mul_result_s    = mul_slot_s.man;
                    norm_redundant_mul_s = mul_slot_s.redundant;
                end
                SRC_DIV: begin
                    norm_exp_s           = div_slot_s.exp;
                    norm_sign_s          = div_slot_s.sign;
                    norm_div_mul_s       = 1'b1;
                    norm_div_result_s    = div_slot_s.man;
                    // low by construction: the divider slot loads it tied to 0
                    norm_redundant_mul_s = div_slot_s.redundant;
                end
                default: begin
                    norm_exp_s           = '0;
                    norm_sign_s          = 1'b0;
                end
            endcase
        end else begin
            norm_exp_s  = '0;
            norm_sign_s = 1'b0;
        end
    end

    // Output stage and round-robin pointer next state.
    always_comb begin
        res_valid_d     = res_valid_q;
        res_data_d      = res_data_q;
        res_overflow_d  = res_overflow_q;
        res_underflow_d = res_underflow_q;
        res_src_d       = res_src_q;
        res_tag_d       = res_tag_q;
        last_grant_d    = last_grant_q;
        if (flush) begin
            res_valid_d  = 1'b0;
            last_grant_d = SRC_DIV;
        end else if (issue_s) begin
            res_valid_d     = 1'b1;
            res_data_d      = bus.norm_result;
            res_overflow_d  = bus.norm_overflow;
            res_underflow_d = bus.norm_underflow;
            res_src_d       = grant_s;
            res_tag_d       = (grant_s == SRC_DIV) ? div_slot_s.tag : mul_slot_s.tag;
            last_grant_d    = grant_s;
        end else if (out_free_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Result register and grant pointer; the divider is "last" out of reset
    // so the multiplier wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q     <= 1'b0;
            res_data_q      <= '0;
            res_overflow_q  <= 1'b0;
            res_underflow_q <= 1'b0;
            res_src_q       <= 1'b0;
            res_tag_q       <= '0;
            last_grant_q    <= SRC_DIV;
        end else begin
            res_valid_q     <= res_valid_d;
            res_data_q      <= res_data_d;
            res_overflow_q  <= res_overflow_d;
            res_underflow_q <= res_underflow_d;
            res_src_q       <= res_src_d;
            res_tag_q       <= res_tag_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign bus.mul_ready          = mul_ready_s;
    assign bus.div_ready          = div_ready_s;
    assign bus.norm_exp           = norm_exp_s;
    assign bus.norm_mul_result    = norm_mul_result_s;
    assign bus.norm_div_result    = norm_div_result_s;
    assign bus.norm_redundant_mul = norm_redundant_mul_s;
    assign bus.norm_div_mul       = norm_div_mul_s;
    assign bus.norm_sign          = norm_sign_s;
    assign bus.res_valid          = res_valid_q;
    assign bus.res_data           = res_data_q;
    assign bus.res_overflow       = res_overflow_q;
    assign bus.res_underflow      = res_underflow_q;
    assign bus.res_src            = res_src_q;
    assign bus.res_tag            = res_tag_q;

endmodule

// File: tb/tb_md_norm_sched.sv
// Bench for md_norm_sched: a simple behavioural normalizer answers on the
// norm_* port, directed requests push hand-computed results into a queue
// and a monitor compares every accepted result against it.
module tb_md_norm_sched;
    import FPU_192_Package::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    md_norm_sched_if bus();

    md_norm_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [37:0] exp_q[$];

    // result record: {src, tag, overflow, underflow, data}
    function automatic logic [37:0] mk(input logic src, input logic [2:0] tag,
                                       input logic ovf, input logic unf,
                                       input logic [31:0] data);
        return {src, tag, ovf, unf, data};
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Behavioural normalizer: redundant product shifts right by one,
    // otherwise shift left until the hidden bit is set.
    logic [23:0] nm_man;
    int          nm_exp;
    logic        nm_ovf;
    logic        nm_unf;
    logic [31:0] nm_res;
    always_comb begin
        nm_man = bus.norm_div_mul ? bus.norm_div_result : bus.norm_mul_result;
        nm_exp = int'(bus.norm_exp);
        if (!bus.norm_div_mul && bus.norm_redundant_mul) begin
            nm_man = {1'b1, nm_man[23:1]};
            nm_exp = nm_exp + 1;
        end else if (nm_man != 24'h0) begin
            for (int i = 0; i < 23; i++) begin
                if (!nm_man[23]) begin
                    nm_man = nm_man << 1;
                    nm_exp = nm_exp - 1;
                end
            end
        end
        nm_ovf = (nm_exp >= 255);
        nm_unf = (nm_man != 24'h0) && (nm_exp <= 0);
        if (nm_man == 24'h0)  nm_res = {bus.norm_sign, 31'h0};
        else if (nm_ovf)      nm_res = {bus.norm_sign, 8'hFF, 23'h0};
        else if (nm_unf)      nm_res = {bus.norm_sign, 31'h0};
        else                  nm_res = {bus.norm_sign, nm_exp[7:0], nm_man[22:0]};
    end
    assign bus.norm_result    = nm_res;
    assign bus.norm_overflow  = nm_ovf;
    assign bus.norm_underflow = nm_unf;

    // Monitor: every accepted result must match the head of the queue.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %h expected none",
                             {bus.res_src, bus.res_tag, bus.res_overflow, bus.res_underflow, bus.res_data});
                end else begin
                    e = exp_q.pop_front();
                    check("result", {bus.res_src, bus.res_tag, bus.res_overflow,
                                     bus.res_underflow, bus.res_data}, e);
                end
            end
        end
    end

    // Hold a multiplier request until accepted (called at posedge+1).
    task automatic send_mul(input logic [7:0] e, input logic [23:0] m, input logic r,
                            input logic s, input logic [2:0] t);
        bit done = 1'b0;
        bus.mul_valid = 1'b1; bus.mul_exp = e; bus.mul_man = m;
        bus.mul_redundant = r; bus.mul_sign = s; bus.mul_tag = t;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.mul_ready) begin
                done = 1'b1;
                @(posedge clk); #1;
            end
        end
        bus.mul_valid = 1'b0;
        if (!done) check("mul_accept_timeout", 38'd0, 38'd1);
    endtask

    task automatic send_div(input logic [7:0] e, input logic [23:0] m,
                            input logic s, input logic [2:0] t);
        bit done = 1'b0;
        bus.div_valid = 1'b1; bus.div_exp = e; bus.div_man = m;
        bus.div_sign = s; bus.div_tag = t;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.div_ready) begin
                done = 1'b1;
                @(posedge clk); #1;
            end
        end
        bus.div_valid = 1'b0;
        if (!done) check("div_accept_timeout", 38'd0, 38'd1);
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input string name);
        for (int c = 0; c < 60; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 38'(exp_q.size()), 38'd0);
        exp_q.delete();
    endtask

    logic [38:0] snap;

    initial begin
        bus.mul_valid = 1'b0; bus.mul_exp = 8'h0; bus.mul_man = 24'h0;
        bus.mul_redundant = 1'b0; bus.mul_sign = 1'b0; bus.mul_tag = 3'h0;
        bus.div_valid = 1'b0; bus.div_exp = 8'h0; bus.div_man = 24'h0;
        bus.div_sign = 1'b0; bus.div_tag = 3'h0;
        bus.res_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_res_valid", 38'(bus.res_valid), 38'd0);
        check("rst_res_fields", {bus.res_src, bus.res_tag, bus.res_overflow,
                                 bus.res_underflow, bus.res_data}, 38'd0);
        check("rst_readys", 38'({bus.mul_ready, bus.div_ready}), 38'd3);

        // multiplier only, redundant product
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b0, 3'd5, 1'b0, 1'b0, 32'h40E00000));
        send_mul(8'h80, 24'hC00000, 1'b1, 1'b0, 3'd5);
        @(negedge clk);
        check("mul_issue_div_mul", 38'(bus.norm_div_mul), 38'd0);
        check("mul_issue_drive", 38'({bus.norm_redundant_mul, bus.norm_mul_result, bus.norm_div_result}),
              38'({1'b1, 24'hC00000, 24'h0}));
        drain("drain_mul_only");

        // divider only
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b1, 3'd2, 1'b0, 1'b0, 32'hBF000000));
        send_div(8'h7F, 24'h400000, 1'b1, 3'd2);
        @(negedge clk);
        check("div_issue_div_mul", 38'(bus.norm_div_mul), 38'd1);
        check("div_issue_drive", 38'({bus.norm_redundant_mul, bus.norm_mul_result, bus.norm_div_result}),
              38'({1'b0, 24'h0, 24'h400000}));
        drain("drain_div_only");

        // underflow, overflow, all-zero divider mantissa
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b1, 3'd3, 1'b0, 1'b1, 32'h00000000));
        send_div(8'h00, 24'h400000, 1'b0, 3'd3);
        drain("drain_underflow");
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b0, 3'd6, 1'b1, 1'b0, 32'h7F800000));
        send_mul(8'hFE, 24'h800000, 1'b1, 1'b0, 3'd6);
        drain("drain_overflow");
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b1, 3'd1, 1'b0, 1'b0, 32'h80000000));
        send_div(8'h10, 24'h000000, 1'b1, 3'd1);
        @(negedge clk);
        check("zero_man_drive", 38'({bus.norm_div_mul, bus.norm_exp, bus.norm_div_result}),
              38'({1'b1, 8'h10, 24'h0}));
        drain("drain_zero_man");

        // contention: last grant was the divider, so mul leads
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b0, 3'(i),     1'b0, 1'b0, 32'h40000000 + (32'(i) << 23)));
            exp_q.push_back(mk(1'b1, 3'(i + 4), 1'b0, 1'b0, 32'hC8000000 + (32'(i) << 23)));
        end
        fork
            for (int i = 0; i < 4; i++) send_mul(8'h80 + 8'(i), 24'h800000, 1'b0, 1'b0, 3'(i));
            for (int j = 0; j < 4; j++) send_div(8'h90 + 8'(j), 24'h800000, 1'b1, 3'(j + 4));
        join
        drain("drain_contention");

        // backpressure for 5 cycles with both streams active
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(1'b0, 3'(i), 1'b0, 1'b0, 32'h50000000 + (32'(i) << 23)));
            exp_q.push_back(mk(1'b1, 3'(i), 1'b0, 1'b0, 32'hD8000000 + (32'(i) << 23)));
        end
        fork
            for (int i = 0; i < 6; i++) send_mul(8'hA0 + 8'(i), 24'h800000, 1'b0, 1'b0, 3'(i));
            for (int j = 0; j < 6; j++) send_div(8'hB0 + 8'(j), 24'h800000, 1'b1, 3'(j));
            begin
                repeat (3) @(posedge clk);
                #1 bus.res_ready = 1'b0;
                @(negedge clk);
                snap = {bus.res_valid, bus.res_src, bus.res_tag, bus.res_overflow,
                        bus.res_underflow, bus.res_data};
                check("bp_valid", 38'(bus.res_valid), 38'd1);
                check("bp_readys", 38'({bus.mul_ready, bus.div_ready}), 38'd0);
                for (int k = 1; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_hold", {bus.res_src, bus.res_tag, bus.res_overflow,
                                      bus.res_underflow, bus.res_data}, snap[37:0]);
                    check("bp_readys", 38'({bus.mul_ready, bus.div_ready}), 38'd0);
                end
                @(posedge clk); #1 bus.res_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // flush with both slots full behind a stalled result
        @(posedge clk); #1 bus.res_ready = 1'b0;
        send_mul(8'h80, 24'h800000, 1'b0, 1'b0, 3'd1);
        fork
            send_mul(8'h81, 24'h800000, 1'b0, 1'b0, 3'd2);
            send_div(8'h82, 24'h800000, 1'b1, 3'd3);
        join
        @(negedge clk);
        check("pre_flush_readys", 38'({bus.mul_ready, bus.div_ready, bus.res_valid}), 38'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_readys", 38'({bus.mul_ready, bus.div_ready}), 38'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_res_valid", 38'(bus.res_valid), 38'd0);
        check("flush_readys_back", 38'({bus.mul_ready, bus.div_ready}), 38'd3);
        @(posedge clk); #1 bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_no_stale", 38'(bus.res_valid), 38'd0);
        end

        // asynchronous reset mid-stream
        @(posedge clk); #1 bus.res_ready = 1'b0;
        send_mul(8'h80, 24'h800000, 1'b0, 1'b0, 3'd4);
        fork
            send_mul(8'h81, 24'h800000, 1'b0, 1'b0, 3'd5);
            send_div(8'h82, 24'h800000, 1'b1, 3'd6);
        join
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 38'({bus.res_valid, bus.mul_ready, bus.div_ready}), 38'd3);
        check("arst_data", 38'(bus.res_data), 38'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arst_no_stale", 38'(bus.res_valid), 38'd0);
        end

        // recovery after reset
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b0, 3'd7, 1'b0, 1'b0, 32'h3F800000));
        send_mul(8'h7F, 24'h800000, 1'b0, 1'b0, 3'd7);
        drain("drain_recovery");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
